// File: rtl/hier_inject_pkg.sv
// Shared types and default sizing for the hier_inject stage chain and its injector.
package hier_inject_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 3;
    localparam int DEF_HOLDW = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FORCE   = 2'd1,
        RELEASE = 2'd2
    } inj_state_e;

endpackage

// File: rtl/hier_inject_stage.sv
// One chain register: a force overrides the shift path, which overrides hold.
module hier_inject_stage
    import hier_inject_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] shift_in,
    input  logic             force_en,
    input  logic [WIDTH-1:0] force_data,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    always_comb begin
        q_d = q_q;
        if (force_en) begin
            q_d = force_data;
        end else if (shift_en) begin
            q_d = shift_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/hier_inject.sv
// DEPTH-stage shift chain with a fault injector that forces one stage for hold+1 cycles.
// Optional read-back tap enabled by defining HIER_INJECT_TAP_EN; otherwise tap_O is 0.
module hier_inject
    import hier_inject_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int HOLDW = DEF_HOLDW,
    localparam int SELW = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             ASYNCRESETN,
    input  logic [WIDTH-1:0] I,
    input  logic             en,
    output logic [WIDTH-1:0] O,
    input  logic             inj_valid,
    output logic             inj_ready,
    input  logic [SELW-1:0]  inj_sel,
    input  logic [WIDTH-1:0] inj_data,
    input  logic [HOLDW-1:0] inj_hold,
    output logic             inj_active,
    input  logic [SELW-1:0]  tap_sel,
    output logic [WIDTH-1:0] tap_O
);

    inj_state_e       state_q, state_d;
    logic [SELW-1:0]  sel_q, sel_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [HOLDW-1:0] hold_q, hold_d;
    logic             force_active;
    logic [WIDTH-1:0] stage_q [DEPTH];

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        data_d     = data_q;
        hold_d     = hold_q;
        inj_ready  = 1'b0;
        inj_active = 1'b0;
        unique case (state_q)
            IDLE: begin
                inj_ready = 1'b1;
                if (inj_valid) begin
                    sel_d   = inj_sel;
                    data_d  = inj_data;
                    hold_d  = inj_hold;
                    state_d = FORCE;
                end
            end
            FORCE: begin
                inj_active = 1'b1;
                if (hold_q == '0) begin
                    state_d = RELEASE;
                end else begin
                    hold_d = hold_q - HOLDW'(1);
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state_q <= IDLE;
            sel_q   <= '0;
            data_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            hold_q  <= hold_d;
        end
    end

    // An out-of-range latched select matches no stage, so the FSM runs but nothing is forced.
    assign force_active = (state_q == FORCE);

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] shift_in;
        if (k == 0) begin : g_head
            assign shift_in = I;
        end else begin : g_body
            assign shift_in = stage_q[k-1];
        end
        hier_inject_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk       (CLK),
            .rst_n     (ASYNCRESETN),
            .shift_en  (en),
            .shift_in  (shift_in),
            .force_en  (force_active && (sel_q == SELW'(k))),
            .force_data(data_q),
            .q         (stage_q[k])
        );
    end

    assign O = stage_q[DEPTH-1];

`ifdef HIER_INJECT_TAP_EN
    always_comb begin
        tap_O = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (tap_sel == SELW'(k)) begin
                tap_O = stage_q[k];
            end
        end
    end
`else
    logic unused_tap_sel;
    assign unused_tap_sel = ^tap_sel;
    assign tap_O          = '0;
`endif

endmodule

// File: doc/hier_inject.md
HIER_INJECT -- requirements
Module: hier_inject

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width of every stage.
REQ-002 SHALL have parameter DEPTH, default 3: number of nested stages, legal range 2..8.
REQ-003 SHALL have parameter HOLDW, default 4: width of the force-hold counter.
REQ-004 SHALL have port CLK, input, 1: the single clock, rising edge.
REQ-005 SHALL have port ASYNCRESETN, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port I, input, WIDTH: chain input to stage 0.
REQ-007 SHALL have port en, input, 1: when high, the chain shifts one stage.
REQ-008 SHALL have port O, output, WIDTH: stage DEPTH-1 register.
REQ-009 SHALL have port inj_valid, input, 1: injection request.
REQ-010 SHALL have port inj_ready, output, 1: injector idle and able to accept a request.
REQ-011 SHALL have port inj_sel, input, clog2(DEPTH): target stage index.
REQ-012 SHALL have port inj_data, input, WIDTH: value to force.
REQ-013 SHALL have port inj_hold, input, HOLDW: extra cycles to keep forcing; 0 means a single cycle.
REQ-014 SHALL have port inj_active, output, 1: a force is in progress.
REQ-015 SHALL have port tap_sel, input, clog2(DEPTH): stage selected for read-back.
REQ-016 SHALL have port tap_O, output, WIDTH: combinational read of stage[tap_sel].

Function
REQ-017 On an en cycle, stage[0] SHALL load I and each stage[k] SHALL load stage[k-1]; stages SHALL hold when en is low.
REQ-018 Injector FSM SHALL have states IDLE, FORCE and RELEASE.
REQ-019 In IDLE, inj_ready SHALL be 1; a request is accepted on inj_valid && inj_ready; acceptance SHALL latch sel, data and hold, and the FSM SHALL move to FORCE.
REQ-020 In FORCE, the latched stage SHALL load the latched data every cycle regardless of en, and inj_active SHALL be 1.
REQ-021 In FORCE, the hold counter SHALL decrement each cycle; FORCE SHALL last hold+1 cycles before moving to RELEASE.
REQ-022 RELEASE SHALL last exactly one cycle with inj_ready=0 and no force, then return to IDLE.
REQ-023 When a shift and a force target the same stage in the same cycle, the force SHALL win; the downstream stage SHALL still take the pre-edge value.
REQ-024 An inj_sel value >= DEPTH SHALL be accepted with no stage forced, and FSM timing SHALL be unchanged.
REQ-025 A tap_sel value >= DEPTH SHALL produce tap_O = 0.
REQ-026 Latency SHALL be I to O = DEPTH en cycles, and inj accept to forced stage visible = 1 cycle.

Reset
REQ-027 Assertion of ASYNCRESETN low SHALL immediately clear all stages, O, tap_O source, counter and latches to 0, and put the FSM in IDLE with inj_ready=1 and inj_active=0.
REQ-028 Reset during FORCE SHALL abort the force with no RELEASE cycle.
REQ-029 Reset deassertion SHALL take effect at the first rising CLK edge afterward.

Configuration
REQ-030 Macro HIER_INJECT_TAP_EN SHALL control the read-back tap; when defined, tap_sel/tap_O SHALL function as specified.
REQ-031 When HIER_INJECT_TAP_EN is undefined, tap_sel SHALL be ignored and tap_O SHALL be tied to 0; ports SHALL remain present in both cases.

Structure
REQ-032 Shared package hier_inject_pkg SHALL hold the FSM state enum (IDLE, FORCE, RELEASE) and the default constants for WIDTH, DEPTH and HOLDW.
REQ-033 Sub-module hier_inject_stage SHALL implement one register with shift/force mux; it SHALL be instantiated DEPTH times in a generate loop.

Verification
REQ-034 Shift test: reset, en=1, I=0x11,0x22,0x33 on consecutive cycles -> O=0x11 on cycle 3, 0x22 on cycle 4, 0x33 on cycle 5.
REQ-035 Single-cycle force: inj_sel=1, inj_data=0xA5, inj_hold=0, en=0 -> stage1=0xA5 one cycle after accept; inj_active high 1 cycle; inj_ready low 2 cycles; O=0xA5 after 1 further en cycle.
REQ-036 Force vs shift contention: inj_hold=3 on stage 0 with en=1 and I=0xFF -> stage0 stays 0xA5 for 4 cycles, stage1 receives 0xA5 while forced, and I resumes in stage 0 in the RELEASE cycle.
REQ-037 Backpressure: inj_valid held high through FORCE/RELEASE -> second acceptance only after IDLE is re-entered (inj_ready=1), with no lost or duplicated force.
REQ-038 Mid-force reset: assert ASYNCRESETN low in the 2nd FORCE cycle -> all outputs 0, inj_ready=1 immediately without waiting for a clock.
REQ-039 Tap/out-of-range: tap_sel=2 shows the stage2 value; tap_sel=3 with DEPTH=3 -> tap_O=0; build without HIER_INJECT_TAP_EN -> tap_O=0 always.
